// File: rtl/alu_share_arb4_pkg.sv
// Shared definitions for the 4-way shared 8-bit ALU arbiter: opcodes, FSM states
// and a one-hot to index helper.
package alu_share_arb4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (oh[k]) idx = 2'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/alu_share_arb4_cells.sv
// Behavioural models of the 8-bit library cells the shared ALU path is built from.
module adder8b (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};
endmodule

module and8b (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_y
);
    assign o_y = i_a & i_b;
endmodule

module or8b (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_y
);
    assign o_y = i_a | i_b;
endmodule

module not8b (
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);
    assign o_y = ~i_a;
endmodule

module mux8_4to1b (
    input  logic [7:0] i_d0,
    input  logic [7:0] i_d1,
    input  logic [7:0] i_d2,
    input  logic [7:0] i_d3,
    input  logic [1:0] i_sel,
    output logic [7:0] o_y
);
    always_comb begin
        case (i_sel)
            2'd0:    o_y = i_d0;
            2'd1:    o_y = i_d1;
            2'd2:    o_y = i_d2;
            default: o_y = i_d3;
        endcase
    end
endmodule

// File: rtl/alu_share_arb4_rr_pick4.sv
// Combinational round-robin picker: first requester at or after i_ptr wins.
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_win,
    output logic       o_any
);
    logic [1:0] w_idx;
    logic       w_found;

    always_comb begin
        o_win   = 4'b0000;
        o_any   = |i_req;
        w_idx   = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_idx = i_ptr + 2'(k);
            if (i_req[w_idx] && !w_found) begin
                o_win[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_share_arb4.sv
// Round-robin sequencer sharing one 8-bit ALU (library cells) among 4 requesters;
// one operation every 3 cycles with a registered result and one-cycle valid.
//
// state | meaning
// IDLE  | arbitrate; on a request latch winner's operands and raise gnt
// EXEC  | ALU evaluates latched operands; result registered at the edge
// DONE  | valid pulse for the served requester; req not sampled
module alu_share_arb4
    import alu_share_arb4_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_req,
    input  logic [31:0] i_a_in,
    input  logic [31:0] i_b_in,
    input  logic [7:0]  i_op_in,
    output logic [3:0]  o_gnt,
    output logic [3:0]  o_valid,
    output logic [7:0]  o_res_out,
    output logic        o_carry_out,
    output logic        o_zero_out
);
    state_t     r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_idx;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [1:0] r_op;

    logic [3:0] w_win;
    logic       w_any;
    logic [1:0] w_widx;
    logic [7:0] w_a_sel;
    logic [7:0] w_b_sel;
    logic [1:0] w_op_sel;
    logic [7:0] w_b_n;
    logic [7:0] w_b_eff;
    logic       w_cin;
    logic [7:0] w_sum;
    logic       w_cout;
    logic [7:0] w_and;
    logic [7:0] w_or;
    logic [7:0] w_res;
    logic       w_carry;

    rr_pick4 u_pick (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_any (w_any)
    );

    assign w_widx = onehot_to_idx(w_win);

    mux8_4to1b u_a_sel (
        .i_d0 (i_a_in[7:0]),   .i_d1 (i_a_in[15:8]),
        .i_d2 (i_a_in[23:16]), .i_d3 (i_a_in[31:24]),
        .i_sel(w_widx),        .o_y  (w_a_sel)
    );

    mux8_4to1b u_b_sel (
        .i_d0 (i_b_in[7:0]),   .i_d1 (i_b_in[15:8]),
        .i_d2 (i_b_in[23:16]), .i_d3 (i_b_in[31:24]),
        .i_sel(w_widx),        .o_y  (w_b_sel)
    );

    always_comb begin
        case (w_widx)
            2'd0:    w_op_sel = i_op_in[1:0];
            2'd1:    w_op_sel = i_op_in[3:2];
            2'd2:    w_op_sel = i_op_in[5:4];
            default: w_op_sel = i_op_in[7:6];
        endcase
    end

    // SUB is A + ~B + 1, so B is inverted and Cin raised only for SUB
    not8b u_not_b (.i_a(r_b), .o_y(w_b_n));

    mux8_4to1b u_b_eff (
        .i_d0 (r_b),  .i_d1 (w_b_n),
        .i_d2 (r_b),  .i_d3 (r_b),
        .i_sel(r_op), .o_y  (w_b_eff)
    );

    assign w_cin = (r_op == OP_SUB);

    adder8b u_add (
        .i_a   (r_a),
        .i_b   (w_b_eff),
        .i_cin (w_cin),
        .o_sum (w_sum),
        .o_cout(w_cout)
    );

    and8b u_and (.i_a(r_a), .i_b(r_b), .o_y(w_and));
    or8b  u_or  (.i_a(r_a), .i_b(r_b), .o_y(w_or));

    mux8_4to1b u_res (
        .i_d0 (w_sum), .i_d1 (w_sum),
        .i_d2 (w_and), .i_d3 (w_or),
        .i_sel(r_op),  .o_y  (w_res)
    );

    assign w_carry = ~r_op[1] & w_cout;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_idx       <= 2'd0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_op        <= OP_ADD;
            o_gnt       <= 4'b0000;
            o_valid     <= 4'b0000;
            o_res_out   <= 8'd0;
            o_carry_out <= 1'b0;
            o_zero_out  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        o_gnt   <= w_win;
                        r_idx   <= w_widx;
                        r_a     <= w_a_sel;
                        r_b     <= w_b_sel;
                        r_op    <= w_op_sel;
                        r_ptr   <= w_widx + 2'd1;
                        r_state <= ST_EXEC;
                    end else begin
                        o_gnt <= 4'b0000;
                    end
                end
                ST_EXEC: begin
                    o_res_out   <= w_res;
                    o_carry_out <= w_carry;
                    o_zero_out  <= (w_res == 8'd0);
                    o_valid     <= 4'b0001 << r_idx;
                    o_gnt       <= 4'b0000;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    o_valid <= 4'b0000;
                    r_state <= ST_IDLE;
                end
                default: begin
                    o_gnt   <= 4'b0000;
                    o_valid <= 4'b0000;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb4.sv
// Scoreboard bench for alu_share_arb4: stimulus pushes expected results computed
// from a behavioural arbitration/ALU model; a monitor checks each valid pulse.
module tb_alu_share_arb4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [7:0]  op_in;
    logic [3:0]  gnt;
    logic [3:0]  valid;
    logic [7:0]  res_out;
    logic        carry_out;
    logic        zero_out;

    alu_share_arb4 dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_a_in     (a_in),
        .i_b_in     (b_in),
        .i_op_in    (op_in),
        .o_gnt      (gnt),
        .o_valid    (valid),
        .o_res_out  (res_out),
        .o_carry_out(carry_out),
        .o_zero_out (zero_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        logic [7:0] res;
        logic       carry;
        logic       zero;
        int         gap;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   model_ptr = 0;

    logic [3:0] mon_prev_gnt = 4'b0;
    logic [3:0] mon_prev_vld = 4'b0;
    int         mon_cyc = 0;
    int         mon_last_v = -100;
    exp_t       mon_e;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference ALU from the opcode definitions, plain arithmetic
    task automatic alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                           output logic [7:0] r, output logic c);
        int s;
        case (op)
            2'b00: begin s = int'(a) + int'(b); r = s[7:0]; c = (s > 255); end
            2'b01: begin s = int'(a) - int'(b); r = s[7:0]; c = (a >= b); end
            2'b10: begin r = a & b; c = 1'b0; end
            default: begin r = a | b; c = 1'b0; end
        endcase
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op);
        a_in[8*i +: 8]  = a;
        b_in[8*i +: 8]  = b;
        op_in[2*i +: 2] = op;
    endtask

    // Monitor: pops one expectation per valid pulse
    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (rst) begin
                mon_prev_gnt = 4'b0;
                mon_prev_vld = 4'b0;
            end else begin
                if (mon_prev_vld != 4'b0)
                    chk("valid_one_cycle", {28'd0, valid & mon_prev_vld}, 32'd0);
                if (valid != 4'b0) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_valid", {28'd0, valid}, 32'd0);
                    end else begin
                        mon_e = sbq.pop_front();
                        chk("valid_onehot", {28'd0, valid}, {28'd0, mon_e.vld});
                        chk("result", {24'd0, res_out}, {24'd0, mon_e.res});
                        chk("carry", {31'd0, carry_out}, {31'd0, mon_e.carry});
                        chk("zero", {31'd0, zero_out}, {31'd0, mon_e.zero});
                        chk("gnt_before_valid", {28'd0, mon_prev_gnt}, {28'd0, mon_e.vld});
                        chk("gnt_clear_at_valid", {28'd0, gnt}, 32'd0);
                        if (mon_e.gap != 0)
                            chk("valid_spacing", 32'(mon_cyc - mon_last_v), 32'(mon_e.gap));
                    end
                    mon_last_v = mon_cyc;
                end
                mon_prev_gnt = gnt;
                mon_prev_vld = valid;
            end
        end
    end

    // One round: requesters in mask each want hold_n operations, dropping req on their last valid
    task automatic run_round(input logic [3:0] mask, input int hold_n, input bit scramble);
        int         rem[4];
        logic [3:0] pend;
        int         nops;
        int         w;
        int         budget;
        bit         first;
        exp_t       e;
        nops  = 0;
        first = 1'b1;
        pend  = mask;
        for (int i = 0; i < 4; i++) rem[i] = mask[i] ? hold_n : 0;
        while (pend != 4'b0) begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && pend[(model_ptr + k) % 4]) w = (model_ptr + k) % 4;
            end
            e.vld = 4'b0001 << w;
            alu_ref(a_in[8*w +: 8], b_in[8*w +: 8], op_in[2*w +: 2], e.res, e.carry);
            e.zero = (e.res == 8'd0);
            e.gap  = first ? 0 : 3;
            first  = 1'b0;
            sbq.push_back(e);
            model_ptr = (w + 1) % 4;
            rem[w]--;
            if (rem[w] == 0) pend[w] = 1'b0;
            nops++;
        end
        for (int i = 0; i < 4; i++) rem[i] = mask[i] ? hold_n : 0;
        budget = nops * 3 + 8;
        @(negedge clk);
        req = mask;
        while (req != 4'b0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (scramble && gnt != 4'b0) begin
                for (int i = 0; i < 4; i++) begin
                    if (gnt[i]) begin
                        a_in[8*i +: 8] = 8'($urandom);
                        b_in[8*i +: 8] = 8'($urandom);
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (valid[i] && req[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) req[i] = 1'b0;
                end
            end
        end
        if (req != 4'b0) begin
            chk("round_timeout", {28'd0, req}, 32'd0);
            req = 4'b0;
        end
        @(negedge clk);
        chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] m;
        int         hold;
        rst   = 1'b1;
        req   = 4'b0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        op_in = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_gnt", {28'd0, gnt}, 32'd0);
        chk("reset_valid", {28'd0, valid}, 32'd0);
        chk("reset_res", {24'd0, res_out}, 32'd0);
        chk("reset_carry", {31'd0, carry_out}, 32'd0);
        chk("reset_zero", {31'd0, zero_out}, 32'd1);

        set_ops(0, 8'hF0, 8'h20, 2'b00); run_round(4'b0001, 1, 1'b0);

        // Reset in EXEC discards the operation
        set_ops(0, 8'h5A, 8'h11, 2'b00);
        @(negedge clk);
        req = 4'b0001;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (gnt[0]) break;
        end
        chk("midop_gnt_seen", {28'd0, gnt}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midop_rst_gnt", {28'd0, gnt}, 32'd0);
        chk("midop_rst_valid", {28'd0, valid}, 32'd0);
        chk("midop_rst_res", {24'd0, res_out}, 32'd0);
        chk("midop_rst_carry", {31'd0, carry_out}, 32'd0);
        chk("midop_rst_zero", {31'd0, zero_out}, 32'd1);
        req = 4'b0;
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        repeat (6) @(negedge clk);

        set_ops(0, 8'h05, 8'h07, 2'b01); run_round(4'b0001, 1, 1'b0);
        set_ops(0, 8'h33, 8'h33, 2'b01); run_round(4'b0001, 1, 1'b0);
        set_ops(0, 8'hCA, 8'h0F, 2'b10); run_round(4'b0001, 1, 1'b0);
        set_ops(0, 8'hCA, 8'h0F, 2'b11); run_round(4'b0001, 1, 1'b0);

        for (int i = 0; i < 4; i++) set_ops(i, 8'($urandom), 8'($urandom), 2'($urandom));
        run_round(4'b1111, 1, 1'b1);
        for (int i = 0; i < 4; i++) set_ops(i, 8'($urandom), 8'($urandom), 2'($urandom));
        run_round(4'b0110, 1, 1'b1);
        set_ops(2, 8'h81, 8'h7F, 2'b00);
        run_round(4'b0100, 3, 1'b0);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 4; i++) set_ops(i, 8'($urandom), 8'($urandom), 2'($urandom));
            m    = 4'($urandom_range(1, 15));
            hold = 1;
            if ($countones(m) == 1 && $urandom_range(0, 1) == 1) hold = $urandom_range(2, 3);
            run_round(m, hold, hold == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
